speed_step_ctrl: RTL
====================

SPEED_STEP_CTRL -- requirements
Module: speed_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a key change.
REQ-002 SHALL have parameter MAX_LEVEL, default 7, meaning the highest speed level (minimum level is 0).
REQ-003 SHALL have parameter LEVEL_W, default 3, meaning the LEVEL width; it must hold MAX_LEVEL.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000, meaning hold cycles before the first auto-repeat step.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 10000000, meaning cycles between subsequent auto-repeat steps.
REQ-006 SHALL have port CLK  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port RSTn  input  1  synchronous active-low reset.
REQ-008 SHALL have port Key1  input  1  raw asynchronous decrement key, active-high when pressed.
REQ-009 SHALL have port Key2  input  1  raw asynchronous increment key, active-high when pressed.
REQ-010 SHALL have port ENABLE  output  1  one-cycle step pulse to the speed counter.
REQ-011 SHALL have port UP_DOWN  output  1  step direction, 1 = decrement, 0 = increment; valid while ENABLE=1.
REQ-012 SHALL have port LEVEL  output  LEVEL_W  shadow of the counter value, 0..MAX_LEVEL.
REQ-013 SHALL have port AT_MIN / AT_MAX  output  1 each  LEVEL==0 / LEVEL==MAX_LEVEL.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced state changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles, and any bounce restarts the count.
REQ-015 The FSM SHALL have states IDLE, STEP, HOLD and LOCK; all outputs are registered.
REQ-016 IDLE -> STEP SHALL occur on a debounced rising edge of exactly one key, latching its direction into UP_DOWN.
REQ-017 STEP SHALL last one cycle: ENABLE=1 and LEVEL±1 only when not saturated (not AT_MAX for increment, not AT_MIN for decrement); otherwise ENABLE stays 0 and LEVEL holds. STEP -> HOLD.
REQ-018 HOLD -> IDLE SHALL occur when the active key is debounced-released.
REQ-019 Both keys debounced-pressed in any state SHALL go to LOCK with no step; LOCK -> IDLE only when both are released.
REQ-020 Latency: a raw press first sampled high at edge N and held stable SHALL give ENABLE=1 for exactly one cycle, starting at edge N+DEBOUNCE_CYCLES+2.
REQ-021 LEVEL SHALL never wrap; ENABLE SHALL never be asserted at a saturated bound, so the external counter stays in step with LEVEL.
REQ-022 ENABLE SHALL be 0 in IDLE, HOLD and LOCK, except for the auto-repeat pulses of REQ-027.

Reset
REQ-023 RSTn=0 sampled at a rising CLK edge SHALL give state IDLE, ENABLE=0, UP_DOWN=0, LEVEL=0, AT_MIN=1, AT_MAX=0, and clear the synchronizers, debounced states and all counters.
REQ-024 Reset mid-operation, including during STEP, SHALL suppress any pending pulse; a key still held after reset release SHALL count as a new press once debounced.
REQ-025 RSTn SHALL have no effect between clock edges.

Configuration
REQ-026 Macro SPEED_AUTOREPEAT_EN SHALL control auto-repeat.
REQ-027 With SPEED_AUTOREPEAT_EN defined, HOLD SHALL issue one step REPEAT_DELAY cycles after STEP, then one every REPEAT_PERIOD cycles while the key is held; each step obeys the saturation rule of REQ-017.
REQ-028 Without SPEED_AUTOREPEAT_EN, one press SHALL give exactly one step and no repeat timer logic is synthesized.

Verification (DEBOUNCE_CYCLES=4, MAX_LEVEL=3, LEVEL_W=2, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 Key2 high sampled at edge 0 and held 20 cycles, no macro -> ENABLE=1, UP_DOWN=0 only in the cycle after edge 6; LEVEL 0->1.
REQ-030 Key2 toggling every 2 cycles for 12 cycles, then low -> ENABLE never asserted; LEVEL=0.
REQ-031 Four Key2 presses then Key1 press at LEVEL=0 -> three ENABLE pulses, LEVEL=3, AT_MAX=1 with no fourth pulse; Key1 press gives UP_DOWN=1, LEVEL=2.
REQ-032 Key1 and Key2 rising on the same edge, held 10 cycles, released -> state LOCK, no ENABLE; IDLE after both are debounced-released.
REQ-033 SPEED_AUTOREPEAT_EN, Key2 held 30 cycles from LEVEL=0 -> pulses at edges 6, 16 and 21, then none; LEVEL=3.
REQ-034 RSTn=0 for 1 cycle at edge 5 of a Key2 press -> no pulse at edge 6; LEVEL=0; pulse at edge 6+6 if Key2 is still held.

Source files
------------

// File: rtl/speed_step_ctrl.sv
// Two-key speed stepper: synchronised, debounced keys drive an IDLE/STEP/HOLD/LOCK FSM
// that issues saturating step pulses. Define SPEED_AUTOREPEAT_EN for held-key auto-repeat.
//
// state | meaning
// IDLE  | waiting for a debounced press of exactly one key
// STEP  | one-cycle step (ENABLE=1 unless saturated)
// HOLD  | step key still held; auto-repeat timer runs when enabled
// LOCK  | both keys pressed; waits for both released
module speed_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_LEVEL       = 7,
  parameter int LEVEL_W         = 3,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Key1,
  input  logic               Key2,
  output logic               ENABLE,
  output logic               UP_DOWN,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               AT_MIN,
  output logic               AT_MAX
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(MAX_LEVEL);

  if (LEVEL_W < $clog2(MAX_LEVEL + 1) || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("speed_step_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2,
    LOCK = 2'd3
  } state_t;

  state_t state, state_nxt;

  // bit 0 = Key1 (decrement), bit 1 = Key2 (increment)
  logic [1:0]      sync1, sync2, deb, deb_q;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      rise;
  logic            step, dir_nxt, sat, pulse;
  logic [LEVEL_W-1:0] level_nxt;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_q     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {Key2, Key1};
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

`ifdef SPEED_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_hit;
`endif

  always_comb begin
    state_nxt = state;
    dir_nxt   = UP_DOWN;
    step      = 1'b0;
`ifdef SPEED_AUTOREPEAT_EN
    rpt_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (&deb) begin
          state_nxt = LOCK;
        end else if (rise[1]) begin
          state_nxt = STEP;
          dir_nxt   = 1'b0;
          step      = 1'b1;
        end else if (rise[0]) begin
          state_nxt = STEP;
          dir_nxt   = 1'b1;
          step      = 1'b1;
        end
      end
      STEP: begin
        state_nxt = (&deb) ? LOCK : HOLD;
      end
      HOLD: begin
        if (&deb) begin
          state_nxt = LOCK;
        end else if (UP_DOWN ? !deb[0] : !deb[1]) begin
          state_nxt = IDLE;
        end
`ifdef SPEED_AUTOREPEAT_EN
        else if (rpt_cnt == '0) begin
          rpt_hit = 1'b1;
          step    = 1'b1;
        end
`endif
      end
      LOCK: begin
        if (deb == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturation is judged against the current level so ENABLE never leaves the counter behind.
  always_comb begin
    sat       = dir_nxt ? AT_MIN : AT_MAX;
    pulse     = step && !sat;
    level_nxt = LEVEL;
    if (pulse) level_nxt = dir_nxt ? (LEVEL - 1'b1) : (LEVEL + 1'b1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= IDLE;
      ENABLE  <= 1'b0;
      UP_DOWN <= 1'b0;
      LEVEL   <= '0;
      AT_MIN  <= 1'b1;
      AT_MAX  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ENABLE  <= pulse;
      UP_DOWN <= dir_nxt;
      LEVEL   <= level_nxt;
      AT_MIN  <= (level_nxt == '0);
      AT_MAX  <= (level_nxt == LVL_MAX);
    end
  end

`ifdef SPEED_AUTOREPEAT_EN
  // Loaded on entry to STEP, so the first repeat lands REPEAT_DELAY edges after the step edge.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rpt_cnt <= '0;
    end else if (state_nxt == STEP) begin
      rpt_cnt <= RPT_W'(REPEAT_DELAY - 1);
    end else if (rpt_hit) begin
      rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
    end else if (rpt_cnt != '0) begin
      rpt_cnt <= rpt_cnt - 1'b1;
    end
  end
`endif

endmodule
